// File: rtl/vliw_rf_pkg.sv
// Shared types and constants for the two-slot VLIW register file and its control neighbours.
package vliw_rf_pkg;

   localparam int NUM_REGS_DEF = 8;
   localparam int DATA_W_DEF   = 32;
   localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

   typedef logic [AW_DEF-1:0] regAddr_t;

   localparam logic [DATA_W_DEF-1:0] RF_RESET_VALUE = '0;

   // Redirect target used by control on exceptions; it flushes the scoreboard at the same time.
   localparam logic [31:0] EXCEPTION_HANDLER_ADDRESS = 32'h0000_0100;

endpackage

// File: rtl/vliw_regfile_sb_scoreboard.sv
// Load scoreboard: per-register busy bits, registered popcount, combinational issue stall.
// With RF_BYPASS_EN defined, a busy bit being cleared by this cycle's load return does not stall.
module rf_scoreboard
   import vliw_rf_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   localparam int AW = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                issValid,
   input  logic [AW-1:0]       raAluRm,
   input  logic [AW-1:0]       raAluRn,
   input  logic [AW-1:0]       raMemRn,
   input  logic [AW-1:0]       raMemRd,
   input  logic [AW-1:0]       issAluWa,
   input  logic                issAluWen,
   input  logic                ldIssue,
   input  logic [AW-1:0]       ldRd,
   input  logic                flush,
   input  logic                memWe,
   input  logic [AW-1:0]       memWa,
   output logic                stall,
   output logic [NUM_REGS-1:0] busy,
   output logic [AW:0]         pendingCnt
);

   logic [NUM_REGS-1:0] busyReg;
   logic [NUM_REGS-1:0] busyNext;
   logic [NUM_REGS-1:0] busyEff;
   logic [AW:0]         cntReg;
   logic [AW:0]         cntNext;

   always_comb begin
      busyEff = busyReg;
`ifdef RF_BYPASS_EN
      if (memWe) busyEff[memWa] = 1'b0;
`endif
      stall = issValid & (busyEff[raAluRm] | busyEff[raAluRn] | busyEff[raMemRn] | busyEff[raMemRd]
                          | (issAluWen & busyEff[issAluWa]) | (ldIssue & busyEff[ldRd]));
   end

   // Later assignments win: flush over new load over load return.
   always_comb begin
      busyNext = busyReg;
      if (memWe) busyNext[memWa] = 1'b0;
      if (ldIssue && !stall) busyNext[ldRd] = 1'b1;
      if (flush) busyNext = '0;
      cntNext = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         cntNext = cntNext + (AW+1)'(busyNext[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busyReg <= '0;
         cntReg  <= '0;
      end else begin
         busyReg <= busyNext;
         cntReg  <= cntNext;
      end
   end

   assign busy       = busyReg;
   assign pendingCnt = cntReg;

endmodule

// File: rtl/vliw_regfile_sb.sv
// Two-write/four-read register file with load scoreboard for the two-slot VLIW datapath.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module vliw_regfile_sb
   import vliw_rf_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   localparam int AW = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                alu_we,
   input  logic [AW-1:0]       alu_wa,
   input  logic [DATA_W-1:0]   alu_wd,
   input  logic                mem_we,
   input  logic [AW-1:0]       mem_wa,
   input  logic [DATA_W-1:0]   mem_wd,
   input  logic [AW-1:0]       alu_ra_rm,
   input  logic [AW-1:0]       alu_ra_rn,
   input  logic [AW-1:0]       mem_ra_rn,
   input  logic [AW-1:0]       mem_ra_rd,
   output logic [DATA_W-1:0]   alu_rd_rm,
   output logic [DATA_W-1:0]   alu_rd_rn,
   output logic [DATA_W-1:0]   mem_rd_rn,
   output logic [DATA_W-1:0]   mem_rd_rd,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_alu_wa,
   input  logic                iss_alu_wen,
   input  logic                ld_issue,
   input  logic [AW-1:0]       ld_rd,
   input  logic                flush,
   output logic                stall,
   output logic [NUM_REGS-1:0] busy,
   output logic [AW:0]         pending_cnt,
   output logic                wr_conflict
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              wrConflictReg;
   logic [AW-1:0]     raVec [4];
   logic [DATA_W-1:0] rdVec [4];

   // MEM write is issued last so it overrides the ALU write on an address collision.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_W'(RF_RESET_VALUE);
         wrConflictReg <= 1'b0;
      end else begin
         if (alu_we) regs[alu_wa] <= alu_wd;
         if (mem_we) regs[mem_wa] <= mem_wd;
         wrConflictReg <= alu_we & mem_we & (alu_wa == mem_wa);
      end
   end

   function automatic logic [DATA_W-1:0] readPort(input logic [AW-1:0] addr);
      logic [DATA_W-1:0] val;
      val = regs[addr];
`ifdef RF_BYPASS_EN
      if (alu_we && (alu_wa == addr)) val = alu_wd;
      if (mem_we && (mem_wa == addr)) val = mem_wd;
`endif
      return val;
   endfunction

   assign raVec[0] = alu_ra_rm;
   assign raVec[1] = alu_ra_rn;
   assign raVec[2] = mem_ra_rn;
   assign raVec[3] = mem_ra_rd;

   for (genvar gi = 0; gi < 4; gi++) begin : gReadPort
      assign rdVec[gi] = readPort(raVec[gi]);
   end

   assign alu_rd_rm   = rdVec[0];
   assign alu_rd_rn   = rdVec[1];
   assign mem_rd_rn   = rdVec[2];
   assign mem_rd_rd   = rdVec[3];
   assign wr_conflict = wrConflictReg;

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) uScoreboard (
      .clk        (clk),
      .reset      (reset),
      .issValid   (iss_valid),
      .raAluRm    (alu_ra_rm),
      .raAluRn    (alu_ra_rn),
      .raMemRn    (mem_ra_rn),
      .raMemRd    (mem_ra_rd),
      .issAluWa   (iss_alu_wa),
      .issAluWen  (iss_alu_wen),
      .ldIssue    (ld_issue),
      .ldRd       (ld_rd),
      .flush      (flush),
      .memWe      (mem_we),
      .memWa      (mem_wa),
      .stall      (stall),
      .busy       (busy),
      .pendingCnt (pending_cnt)
   );

   // An ALU writeback must never target a register still waiting for load data.
   aluWriteNotBusy: assert property (@(posedge clk) disable iff (!reset) !(alu_we && busy[alu_wa]));

endmodule

// File: tb/tb_vliw_regfile_sb.sv
// Directed, table-driven bench for vliw_regfile_sb in its default (no bypass) build.
module tb_vliw_regfile_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_we, mem_we;
   logic [2:0]  alu_wa, mem_wa;
   logic [31:0] alu_wd, mem_wd;
   logic [2:0]  alu_ra_rm, alu_ra_rn, mem_ra_rn, mem_ra_rd;
   logic [31:0] alu_rd_rm, alu_rd_rn, mem_rd_rn, mem_rd_rd;
   logic        iss_valid, iss_alu_wen, ld_issue, flush;
   logic [2:0]  iss_alu_wa, ld_rd;
   logic        stall, wr_conflict;
   logic [7:0]  busy;
   logic [3:0]  pending_cnt;

   int passCnt = 0;
   int totalCnt = 0;

   always #5 clk = ~clk;

   vliw_regfile_sb dut (
      .clk(clk), .reset(reset),
      .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
      .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
      .alu_ra_rm(alu_ra_rm), .alu_ra_rn(alu_ra_rn), .mem_ra_rn(mem_ra_rn), .mem_ra_rd(mem_ra_rd),
      .alu_rd_rm(alu_rd_rm), .alu_rd_rn(alu_rd_rn), .mem_rd_rn(mem_rd_rn), .mem_rd_rd(mem_rd_rd),
      .iss_valid(iss_valid), .iss_alu_wa(iss_alu_wa), .iss_alu_wen(iss_alu_wen),
      .ld_issue(ld_issue), .ld_rd(ld_rd), .flush(flush),
      .stall(stall), .busy(busy), .pending_cnt(pending_cnt), .wr_conflict(wr_conflict)
   );

   typedef struct {
      logic        aWe;  logic [2:0] aWa;  logic [31:0] aWd;
      logic        mWe;  logic [2:0] mWa;  logic [31:0] mWd;
      logic [11:0] ra;
      logic        issV; logic [2:0] issWa; logic issWen;
      logic        ldI;  logic [2:0] ldRd; logic flush;
      logic        expStall; int chkPort; logic [31:0] expRd;
      logic [7:0]  expBusy; logic [3:0] expCnt; logic expConf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic aWe, input logic [2:0] aWa, input logic [31:0] aWd,
      input logic mWe, input logic [2:0] mWa, input logic [31:0] mWd,
      input logic [11:0] ra,
      input logic issV, input logic [2:0] issWa, input logic issWen,
      input logic ldI, input logic [2:0] ldRd, input logic fl,
      input logic expStall, input int chkPort, input logic [31:0] expRd,
      input logic [7:0] expBusy, input logic [3:0] expCnt, input logic expConf);
      vec_t v;
      v.aWe = aWe; v.aWa = aWa; v.aWd = aWd;
      v.mWe = mWe; v.mWa = mWa; v.mWd = mWd;
      v.ra = ra; v.issV = issV; v.issWa = issWa; v.issWen = issWen;
      v.ldI = ldI; v.ldRd = ldRd; v.flush = fl;
      v.expStall = expStall; v.chkPort = chkPort; v.expRd = expRd;
      v.expBusy = expBusy; v.expCnt = expCnt; v.expConf = expConf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle();
      alu_we = 0; alu_wa = 0; alu_wd = 0;
      mem_we = 0; mem_wa = 0; mem_wd = 0;
      alu_ra_rm = 0; alu_ra_rn = 0; mem_ra_rn = 0; mem_ra_rd = 0;
      iss_valid = 0; iss_alu_wa = 0; iss_alu_wen = 0;
      ld_issue = 0; ld_rd = 0; flush = 0;
   endtask

   function automatic logic [31:0] rdSel(input int p);
      case (p)
         0: return alu_rd_rm;
         1: return alu_rd_rn;
         2: return mem_rd_rn;
         default: return mem_rd_rd;
      endcase
   endfunction

   initial begin
      vec_t v;
      logic [7:0] expMask;
      idle();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk) #1;

      // Reset: a written register and an in-flight load are both discarded by async reset.
      alu_we = 1; alu_wa = 3; alu_wd = 32'hDEADBEEF; ld_issue = 1; ld_rd = 5;
      @(posedge clk) #1;
      idle();
      alu_ra_rm = 3; alu_ra_rn = 3; mem_ra_rn = 3; mem_ra_rd = 3;
      #1 chk("pre_reset_r3", alu_rd_rm, 32'hDEADBEEF);
      chk("pre_reset_busy", 32'(busy), 32'h20);
      reset = 1'b0;
      #1;
      chk("reset_alu_rm", alu_rd_rm, 0);
      chk("reset_alu_rn", alu_rd_rn, 0);
      chk("reset_mem_rn", mem_rd_rn, 0);
      chk("reset_mem_rd", mem_rd_rd, 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_cnt", 32'(pending_cnt), 0);
      chk("reset_conf", 32'(wr_conflict), 0);
      $display("reset sequence: busy=%h cnt=%0d", busy, pending_cnt);
      @(negedge clk) reset = 1'b1;
      @(posedge clk) #1;

      //       aWe aWa aWd     mWe mWa mWd      ra       iV iWa iWen ldI ldRd fl  stall port rd          busy  cnt conf
      vecs.push_back(mk(0, 0, 0,       1, 5, 'h66,  'o0000, 0, 0, 0,   0, 0, 0,   0, 0, 'h0,        'h00, 0, 0));
      vecs.push_back(mk(0, 0, 0,       0, 0, 0,     'o5000, 0, 0, 0,   0, 0, 0,   0, 0, 'h66,       'h00, 0, 0));
      vecs.push_back(mk(1, 1, 'h11,    1, 2, 'h22,  'o0000, 0, 0, 0,   0, 0, 0,   0, 0, 'h0,        'h00, 0, 0));
      vecs.push_back(mk(1, 5, 'hAA,    1, 5, 'hBB,  'o0120, 0, 0, 0,   0, 0, 0,   0, 1, 'h11,       'h00, 0, 1));
      vecs.push_back(mk(0, 0, 0,       0, 0, 0,     'o0025, 0, 0, 0,   0, 0, 0,   0, 3, 'hBB,       'h00, 0, 0));
      vecs.push_back(mk(0, 0, 0,       0, 0, 0,     'o0025, 0, 0, 0,   1, 4, 0,   0, 2, 'h22,       'h10, 1, 0));
      vecs.push_back(mk(0, 0, 0,       0, 0, 0,     'o0400, 1, 0, 0,   0, 0, 0,   1, 1, 'h0,        'h10, 1, 0));
      vecs.push_back(mk(0, 0, 0,       1, 4, 'h55,  'o0004, 1, 0, 0,   0, 0, 0,   1, 3, 'h0,        'h00, 0, 0));
      vecs.push_back(mk(0, 0, 0,       0, 0, 0,     'o4000, 1, 0, 0,   0, 0, 0,   0, 0, 'h55,       'h00, 0, 0));
      vecs.push_back(mk(0, 0, 0,       0, 0, 0,     'o0000, 1, 0, 0,   1, 6, 0,   0, 0, 'h0,        'h40, 1, 0));
      vecs.push_back(mk(0, 0, 0,       0, 0, 0,     'o0000, 1, 0, 0,   1, 6, 0,   1, 0, 'h0,        'h40, 1, 0));
      vecs.push_back(mk(0, 0, 0,       1, 6, 'h99,  'o0000, 0, 0, 0,   1, 6, 0,   0, 0, 'h0,        'h40, 1, 0));
      vecs.push_back(mk(0, 0, 0,       1, 6, 'h9A,  'o0006, 1, 0, 0,   0, 0, 0,   1, 3, 'h99,       'h00, 0, 0));
      vecs.push_back(mk(0, 0, 0,       0, 0, 0,     'o6000, 0, 0, 0,   1, 1, 0,   0, 0, 'h9A,       'h02, 1, 0));
      vecs.push_back(mk(0, 0, 0,       0, 0, 0,     'o0000, 0, 0, 0,   1, 2, 0,   0, 0, 'h0,        'h06, 2, 0));
      vecs.push_back(mk(0, 0, 0,       0, 0, 0,     'o1000, 0, 0, 0,   1, 7, 0,   0, 0, 'h11,       'h86, 3, 0));
      vecs.push_back(mk(0, 0, 0,       0, 0, 0,     'o0000, 1, 7, 0,   0, 0, 0,   0, 0, 'h0,        'h86, 3, 0));
      vecs.push_back(mk(0, 0, 0,       0, 0, 0,     'o0000, 1, 7, 1,   0, 0, 0,   1, 0, 'h0,        'h86, 3, 0));
      vecs.push_back(mk(0, 0, 0,       1, 2, 'h12,  'o0100, 1, 0, 0,   0, 0, 1,   1, 1, 'h11,       'h00, 0, 0));
      vecs.push_back(mk(0, 0, 0,       0, 0, 0,     'o1270, 1, 0, 0,   0, 0, 0,   0, 1, 'h12,       'h00, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         alu_we = v.aWe; alu_wa = v.aWa; alu_wd = v.aWd;
         mem_we = v.mWe; mem_wa = v.mWa; mem_wd = v.mWd;
         {alu_ra_rm, alu_ra_rn, mem_ra_rn, mem_ra_rd} = v.ra;
         iss_valid = v.issV; iss_alu_wa = v.issWa; iss_alu_wen = v.issWen;
         ld_issue = v.ldI; ld_rd = v.ldRd; flush = v.flush;
         @(negedge clk);
         chk($sformatf("v%0d_stall", i), 32'(stall), 32'(v.expStall));
         chk($sformatf("v%0d_rd_port%0d", i, v.chkPort), rdSel(v.chkPort), v.expRd);
         @(posedge clk) #1;
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v.expBusy));
         chk($sformatf("v%0d_cnt", i), 32'(pending_cnt), 32'(v.expCnt));
         chk($sformatf("v%0d_conf", i), 32'(wr_conflict), 32'(v.expConf));
         $display("vec %0d: ra=%o stall_exp=%b busy=%h cnt=%0d conf=%b",
                  i, v.ra, v.expStall, busy, pending_cnt, wr_conflict);
      end
      idle();

      // Fill every register with an outstanding load: count must reach NUM_REGS without wrapping.
      for (int i = 0; i < 8; i++) begin
         ld_issue = 1; ld_rd = 3'(i);
         @(posedge clk) #1;
         expMask = 8'((9'd1 << (i + 1)) - 9'd1);
         chk($sformatf("fill%0d_busy", i), 32'(busy), 32'(expMask));
         chk($sformatf("fill%0d_cnt", i), 32'(pending_cnt), 32'(i + 1));
         $display("fill %0d: busy=%h cnt=%0d", i, busy, pending_cnt);
      end
      // Flush wins over a load issued in the same cycle.
      ld_issue = 1; ld_rd = 3; flush = 1;
      @(posedge clk) #1;
      idle();
      chk("flush_full_busy", 32'(busy), 0);
      chk("flush_full_cnt", 32'(pending_cnt), 0);
      $display("flush after fill: busy=%h cnt=%0d", busy, pending_cnt);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
